// File: rtl/prog_imm_lut.sv
// prog_imm_lut: writable immediate / branch-target lookup table.
//
// A narrow instruction field (rd_addr) indexes a table of DW-bit constants.
// Entries can be rewritten at run time. A sequential restore engine can also
// bulk-rewrite every entry with its built-in default, one entry per cycle.
// Read data is registered, so it appears one cycle after the request.
//
// Ports
//   clk       system clock, all state on the rising edge
//   rst_n     asynchronous active-low reset (table back to defaults)
//   rd_en     read request
//   rd_addr   read index
//   rd_data   registered read data (holds when no read is issued)
//   rd_valid  one-cycle flag: rd_data was updated by the previous edge
//   wr_en     write request (dropped while a restore is running)
//   wr_addr   write index
//   wr_data   write data
//   restore   start a bulk restore of defaults (ignored while busy)
//   busy      restore in progress
//   wr_rej    one-cycle pulse: the write at the previous edge was dropped
module prog_imm_lut #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          restore,
  output logic          busy,
  output logic          wr_rej
);

  localparam int unsigned Depth = 2 ** AW;

  // Built-in default for entry idx; constants wider than DW are truncated.
  function automatic logic [DW-1:0] dflt(input int unsigned idx);
    if (idx < DW) begin
      return DW'(1) << idx;
    end else if (idx == DW + 1) begin
      return DW'(30);
    end else if (idx == DW + 2) begin
      return DW'(7);
    end else if (idx == DW + 3) begin
      return '1;
    end
    return '0;
  endfunction

  typedef enum logic [0:0] {
    StIdle,
    StRestore
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  // Single table write port shared by user writes and the restore engine.
  logic          tbl_wen;
  logic [AW-1:0] tbl_waddr;
  logic [DW-1:0] tbl_wdata;

  logic [DW-1:0] tbl_rd [Depth];
  logic [DW-1:0] dflt_tab [Depth];

  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;
  logic          wr_rej_q;

  // ---------------------------------------------------------------------------
  // Table storage: one register per entry, each resetting to its own default.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < Depth; g++) begin : g_entry
    localparam logic [DW-1:0] Init = dflt(g);

    logic [DW-1:0] entry_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_q <= Init;
      end else if (tbl_wen && (tbl_waddr == AW'(g))) begin
        entry_q <= tbl_wdata;
      end
    end

    assign tbl_rd[g]   = entry_q;
    assign dflt_tab[g] = Init;
  end

  // ---------------------------------------------------------------------------
  // Restore FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Restore FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (restore) begin
          state_d = StRestore;
        end
      end
      StRestore: begin
        // Pointer wraps to zero on the same edge that writes the last entry.
        ptr_d = ptr_q + AW'(1);
        if (&ptr_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Restore FSM: outputs (busy flag and table write-port steering)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = 1'b0;
    tbl_wen   = 1'b0;
    tbl_waddr = wr_addr;
    tbl_wdata = wr_data;
    unique case (state_q)
      StIdle: begin
        tbl_wen = wr_en;
      end
      StRestore: begin
        busy      = 1'b1;
        tbl_wen   = 1'b1;
        tbl_waddr = ptr_q;
        tbl_wdata = dflt_tab[ptr_q];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered read port with write-first bypass, and write-reject pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_rej_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      wr_rej_q   <= wr_en && (state_q == StRestore);
      if (rd_en) begin
        if (tbl_wen && (tbl_waddr == rd_addr)) begin
          rd_data_q <= tbl_wdata;
        end else begin
          rd_data_q <= tbl_rd[rd_addr];
        end
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign wr_rej   = wr_rej_q;

endmodule

// File: tb/tb_prog_imm_lut.sv
module tb_prog_imm_lut;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus: index 0 = AW4/DW8, index 1 = AW5/DW16.
  logic        rst_n   [2];
  logic        rd_en   [2];
  logic [4:0]  rd_addr [2];
  logic        wr_en   [2];
  logic [4:0]  wr_addr [2];
  logic [15:0] wr_data [2];
  logic        restore [2];

  logic [7:0]  rd_data_a;
  logic        rd_valid_a, busy_a, wr_rej_a;
  logic [15:0] rd_data_b;
  logic        rd_valid_b, busy_b, wr_rej_b;

  logic [15:0] got_rd  [2];
  logic        got_val [2];
  logic        got_busy[2];
  logic        got_rej [2];

  assign got_rd[0]   = {8'h00, rd_data_a};
  assign got_rd[1]   = rd_data_b;
  assign got_val[0]  = rd_valid_a;
  assign got_val[1]  = rd_valid_b;
  assign got_busy[0] = busy_a;
  assign got_busy[1] = busy_b;
  assign got_rej[0]  = wr_rej_a;
  assign got_rej[1]  = wr_rej_b;

  prog_imm_lut #(.AW(4), .DW(8)) u_dut_a (
    .clk     (clk),
    .rst_n   (rst_n[0]),
    .rd_en   (rd_en[0]),
    .rd_addr (rd_addr[0][3:0]),
    .rd_data (rd_data_a),
    .rd_valid(rd_valid_a),
    .wr_en   (wr_en[0]),
    .wr_addr (wr_addr[0][3:0]),
    .wr_data (wr_data[0][7:0]),
    .restore (restore[0]),
    .busy    (busy_a),
    .wr_rej  (wr_rej_a)
  );

  prog_imm_lut #(.AW(5), .DW(16)) u_dut_b (
    .clk     (clk),
    .rst_n   (rst_n[1]),
    .rd_en   (rd_en[1]),
    .rd_addr (rd_addr[1]),
    .rd_data (rd_data_b),
    .rd_valid(rd_valid_b),
    .wr_en   (wr_en[1]),
    .wr_addr (wr_addr[1]),
    .wr_data (wr_data[1]),
    .restore (restore[1]),
    .busy    (busy_b),
    .wr_rej  (wr_rej_b)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: table contents as plain arrays, restore as a countdown
  // of remaining busy cycles that walks the table from entry 0 upwards.
  // ---------------------------------------------------------------------------
  int          dep [2] = '{16, 32};
  int          dwv [2] = '{8, 16};
  logic [15:0] m_mem [2][32];
  int          m_left[2];
  logic [15:0] m_rd  [2];
  logic        m_val [2];
  logic        m_rej [2];

  function automatic logic [15:0] dmod(input int i, input int dw);
    int v;
    if (i < dw)           v = 1 << i;
    else if (i == dw + 1) v = 30;
    else if (i == dw + 2) v = 7;
    else if (i == dw + 3) v = -1;
    else                  v = 0;
    return 16'(v & ((1 << dw) - 1));
  endfunction

  function automatic void model_reset(input int k);
    for (int i = 0; i < dep[k]; i++) m_mem[k][i] = dmod(i, dwv[k]);
    m_left[k] = 0;
    m_rd[k]   = '0;
    m_val[k]  = 1'b0;
    m_rej[k]  = 1'b0;
  endfunction

  function automatic void model_step(input int k);
    int          wa, ra;
    logic [15:0] wd;
    logic        wen;
    wen = 1'b0; wa = 0; wd = '0;
    if (m_left[k] > 0) begin
      wen = 1'b1;
      wa  = dep[k] - m_left[k];
      wd  = dmod(wa, dwv[k]);
    end else if (wr_en[k]) begin
      wen = 1'b1;
      wa  = int'(wr_addr[k]) & (dep[k] - 1);
      wd  = 16'(int'(wr_data[k]) & ((1 << dwv[k]) - 1));
    end
    m_rej[k] = (m_left[k] > 0) && wr_en[k];
    if (rd_en[k]) begin
      ra       = int'(rd_addr[k]) & (dep[k] - 1);
      m_rd[k]  = (wen && wa == ra) ? wd : m_mem[k][ra];
      m_val[k] = 1'b1;
    end else begin
      m_val[k] = 1'b0;
    end
    if (wen) m_mem[k][wa] = wd;
    if (m_left[k] > 0) m_left[k]--;
    else if (restore[k]) m_left[k] = dep[k];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n[k]) model_reset(k);
      else model_step(k);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("cyc_rd_data[%0d]", k), 32'(got_rd[k]), 32'(m_rd[k]));
        check($sformatf("cyc_rd_valid[%0d]", k), 32'(got_val[k]), 32'(m_val[k]));
        check($sformatf("cyc_busy[%0d]", k), 32'(got_busy[k]), 32'(m_left[k] > 0));
        check($sformatf("cyc_wr_rej[%0d]", k), 32'(got_rej[k]), 32'(m_rej[k]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic read_chk(input int k, input int a, input logic [15:0] exp, input string nm);
    rd_en[k]   = 1'b1;
    rd_addr[k] = 5'(a);
    tick();
    rd_en[k]   = 1'b0;
    check(nm, 32'(got_rd[k]), 32'(exp));
    check({nm, "_valid"}, 32'(got_val[k]), 32'd1);
  endtask

  task automatic wait_idle(input int k);
    int c = 0;
    while (got_busy[k] && c < 100) begin
      tick();
      c++;
    end
    check("idle_timeout", 32'(got_busy[k]), 32'd0);
  endtask

  // Pulse restore, re-pulse it mid-restore, and count busy cycles.
  task automatic busy_len(input int k, input int exp_len, input string nm);
    int n;
    restore[k] = 1'b1;
    tick();
    restore[k] = 1'b0;
    n = got_busy[k] ? 1 : 0;
    for (int c = 0; c < 100 && got_busy[k]; c++) begin
      restore[k] = (c == 3);
      tick();
      if (got_busy[k]) n++;
    end
    restore[k] = 1'b0;
    check(nm, 32'(n), 32'(exp_len));
  endtask

  localparam logic [7:0] Exp1 [16] = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128,
                                       8'd0, 8'd30, 8'd7, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; rd_en[k] = 1'b0; rd_addr[k] = '0; wr_en[k] = 1'b0;
      wr_addr[k] = '0; wr_data[k] = '0; restore[k] = 1'b0;
      model_reset(k);
    end
    #1;
    check("reset_rd_valid", 32'(rd_valid_a), 32'd0);
    check("reset_busy", 32'(busy_a), 32'd0);
    check("reset_rd_data", 32'(rd_data_a), 32'd0);
    check("reset_wr_rej", 32'(wr_rej_a), 32'd0);
    tick();
    tick();
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    cmp_on   = 1'b1;
    tick();

    // Back-to-back reads of every default entry.
    rd_en[0] = 1'b1;
    for (int a = 0; a < 16; a++) begin
      rd_addr[0] = 5'(a);
      tick();
      check($sformatf("t1_addr%0d", a), 32'(rd_data_a), 32'(Exp1[a]));
      check($sformatf("t1_valid%0d", a), 32'(rd_valid_a), 32'd1);
    end
    rd_en[0] = 1'b0;
    tick();
    check("t1_valid_drop", 32'(rd_valid_a), 32'd0);

    // Write-first bypass, then readback.
    wr_en[0] = 1'b1; wr_addr[0] = 5'd9; wr_data[0] = 16'h005A;
    rd_en[0] = 1'b1; rd_addr[0] = 5'd9;
    tick();
    wr_en[0] = 1'b0; rd_en[0] = 1'b0;
    check("t2_bypass", 32'(rd_data_a), 32'h5A);
    read_chk(0, 9, 16'h5A, "t2_read9");
    read_chk(0, 8, 16'h00, "t2_read8");

    // Restore runs exactly 16 cycles; a second request while busy is ignored.
    busy_len(0, 16, "t3_busy_len");
    read_chk(0, 9, 16'd30, "t3_read9");

    // Write during restore is dropped and flagged.
    restore[0] = 1'b1;
    tick();
    restore[0] = 1'b0;
    wr_en[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 16'h00AA;
    tick();
    wr_en[0] = 1'b0;
    check("t4_wr_rej_pulse", 32'(wr_rej_a), 32'd1);
    tick();
    check("t4_wr_rej_clear", 32'(wr_rej_a), 32'd0);
    wait_idle(0);
    read_chk(0, 3, 16'd8, "t4_read3");
    wr_en[0] = 1'b1; wr_addr[0] = 5'd3; wr_data[0] = 16'h0033;
    tick();
    wr_en[0] = 1'b0;
    check("t4_idle_no_rej", 32'(wr_rej_a), 32'd0);
    read_chk(0, 3, 16'h33, "t4_read3_new");

    // Write and restore on the same edge: write lands, restore overwrites it.
    wr_en[0] = 1'b1; wr_addr[0] = 5'd4; wr_data[0] = 16'h0077;
    restore[0] = 1'b1; rd_en[0] = 1'b1; rd_addr[0] = 5'd4;
    tick();
    wr_en[0] = 1'b0; restore[0] = 1'b0; rd_en[0] = 1'b0;
    check("t4b_bypass", 32'(rd_data_a), 32'h77);
    check("t4b_busy", 32'(busy_a), 32'd1);
    wait_idle(0);
    read_chk(0, 4, 16'd16, "t4b_read4");

    // Reset in the middle of a restore.
    wr_en[0] = 1'b1; wr_addr[0] = 5'd12; wr_data[0] = 16'h0011;
    tick();
    wr_en[0] = 1'b0;
    restore[0] = 1'b1;
    tick();
    restore[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rd_en[0] = (c == 4); rd_addr[0] = 5'd12;
      tick();
    end
    rd_en[0] = 1'b0;
    check("t5_pre_busy", 32'(busy_a), 32'd1);
    check("t5_pre_rd", 32'(rd_data_a), 32'h11);
    #1;
    rst_n[0] = 1'b0;
    model_reset(0);
    #1;
    check("t5_busy_async", 32'(busy_a), 32'd0);
    check("t5_valid_async", 32'(rd_valid_a), 32'd0);
    check("t5_rd_async", 32'(rd_data_a), 32'd0);
    tick();
    rst_n[0] = 1'b1;
    tick();
    check("t5_idle", 32'(busy_a), 32'd0);
    read_chk(0, 12, 16'h00, "t5_read12");
    read_chk(0, 0, 16'h01, "t5_read0");
    wr_en[0] = 1'b1; wr_addr[0] = 5'd12; wr_data[0] = 16'h0022;
    tick();
    wr_en[0] = 1'b0;
    check("t5_idle_write", 32'(wr_rej_a), 32'd0);
    read_chk(0, 12, 16'h22, "t5_read12_new");

    // Wide instance defaults and restore length.
    read_chk(1, 15, 16'h8000, "t6_read15");
    read_chk(1, 16, 16'h0000, "t6_read16");
    read_chk(1, 17, 16'd30, "t6_read17");
    read_chk(1, 18, 16'd7, "t6_read18");
    read_chk(1, 19, 16'hFFFF, "t6_read19");
    read_chk(1, 31, 16'h0000, "t6_read31");
    wr_en[1] = 1'b1; wr_addr[1] = 5'd17; wr_data[1] = 16'hBEEF;
    tick();
    wr_en[1] = 1'b0;
    read_chk(1, 17, 16'hBEEF, "t6_read17_new");
    busy_len(1, 32, "t6_busy_len");
    read_chk(1, 17, 16'd30, "t6_read17_restored");

    tick();
    tick();
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
